// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM port arbiter
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } arb_state_t;

    // Width of the wait-state down counter (WAIT_STATES is 0..15)
    localparam int WCNT_W = 4;

    // Width of a requester index; never narrower than one bit
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - winner selection (round-robin, or fixed priority with SRAM_ARB_FIXED_PRIO_EN)
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_onehot,
    output logic [PW-1:0]   win_idx
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Lowest set request index wins; scanning downwards leaves the lowest one
    always_comb begin
        win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) win_idx = PW'(i);
        end
    end
`else
    logic rr_found;

    // First request at or above the pointer, else wrap to the lowest request
    always_comb begin
        win_idx  = '0;
        rr_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!rr_found && req[i] && (i >= int'(ptr))) begin
                win_idx  = PW'(i);
                rr_found = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!rr_found && req[i]) begin
                win_idx  = PW'(i);
                rr_found = 1'b1;
            end
        end
    end
`endif

    // One-hot form of the winner; all zero when nobody is requesting
    always_comb begin
        win_onehot = '0;
        if (|req) win_onehot[win_idx] = 1'b1;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - single-port SRAM arbiter for NREQ requesters (SRAM_ARB_FIXED_PRIO_EN: fixed priority)
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int dw          = 32,
    parameter int aw          = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*aw-1:0]   req_addr,
    input  logic [NREQ*dw-1:0]   req_wdata,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [dw-1:0]        rdata,
    output logic                 sram_cs,
    output logic                 sram_we,
    output logic [aw-1:0]        sram_addr,
    output logic [dw-1:0]        sram_wdata,
    input  logic [dw-1:0]        sram_rdata
);

    localparam int PW = ptr_width(NREQ);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     ptr;
    logic [WCNT_W-1:0] wcnt;
    logic [NREQ-1:0]   win_onehot;
    logic [PW-1:0]     win_idx;

    sram_arb_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req        (req),
        .ptr        (ptr),
        .win_onehot (win_onehot),
        .win_idx    (win_idx)
    );

    // State register
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next state: IDLE -> ACCESS on any request, ACCESS until the counter expires, one RECOVER cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = ACCESS;
            ACCESS:  if (wcnt == '0) state_nxt = RECOVER;
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant/latch in IDLE, hold the SRAM port through the wait states, complete in the last ACCESS cycle
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            grant      <= '0;
            done       <= '0;
            rdata      <= '0;
            sram_cs    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            owner      <= '0;
            wcnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant      <= win_onehot;
                        owner      <= win_idx;
                        sram_cs    <= 1'b1;
                        sram_we    <= req_we[win_idx];
                        sram_addr  <= req_addr[int'(win_idx)*aw +: aw];
                        sram_wdata <= req_wdata[int'(win_idx)*dw +: dw];
                        wcnt       <= WCNT_W'(WAIT_STATES);
                    end
                end
                ACCESS: begin
                    grant <= '0;
                    if (wcnt != '0) begin
                        wcnt <= wcnt - 1'b1;
                    end else begin
                        sram_cs <= 1'b0;
                        sram_we <= 1'b0;
                        done    <= NREQ'(1) << owner;
                        // sram_we still carries the direction of the access being finished
                        if (!sram_we) rdata <= sram_rdata;
                    end
                end
                RECOVER: begin
                    done <= '0;
                end
                default: begin
                    grant <= '0;
                end
            endcase
        end
    end

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    // Rotate priority to just past the requester that was served
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n)              ptr <= '0;
        else if (state == RECOVER)  ptr <= (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter (2 req/0 ws and 4 req/2 ws)
module tb_sram_port_arbiter;

    localparam int WS_A = 0;
    localparam int WS_B = 2;

    logic wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    int cyc = 0;
    always @(posedge wb_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [3:0] done; logic [31:0] rdata; } done_t;
    typedef struct { logic [9:0] addr; logic [31:0] data; } wr_t;

    logic [3:0] exp_g_a[$];
    logic [3:0] exp_g_b[$];
    done_t      exp_d_a[$];
    done_t      exp_d_b[$];
    wr_t        exp_w_a[$];
    wr_t        exp_w_b[$];

    logic [31:0] a_hold = '0;
    logic [31:0] b_hold = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bg(input logic [9:0] a);
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    // DUT A: 2 requesters, no wait states
    logic        rst_a;
    logic [1:0]  a_req, a_req_we, a_grant, a_done;
    logic [19:0] a_req_addr;
    logic [63:0] a_req_wdata;
    logic [31:0] a_rdata, a_sram_wdata, a_sram_rdata;
    logic        a_sram_cs, a_sram_we;
    logic [9:0]  a_sram_addr;

    sram_port_arbiter #(.NREQ(2), .dw(32), .aw(10), .WAIT_STATES(WS_A)) u_dut_a (
        .wb_clk(wb_clk), .wb_rst_n(rst_a), .req(a_req), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .grant(a_grant), .done(a_done),
        .rdata(a_rdata), .sram_cs(a_sram_cs), .sram_we(a_sram_we), .sram_addr(a_sram_addr),
        .sram_wdata(a_sram_wdata), .sram_rdata(a_sram_rdata)
    );

    // DUT B: 4 requesters, 2 wait states
    logic        rst_b;
    logic [3:0]  b_req, b_req_we, b_grant, b_done;
    logic [39:0] b_req_addr;
    logic [127:0] b_req_wdata;
    logic [31:0] b_rdata, b_sram_wdata, b_sram_rdata;
    logic        b_sram_cs, b_sram_we;
    logic [9:0]  b_sram_addr;

    sram_port_arbiter #(.NREQ(4), .dw(32), .aw(10), .WAIT_STATES(WS_B)) u_dut_b (
        .wb_clk(wb_clk), .wb_rst_n(rst_b), .req(b_req), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .grant(b_grant), .done(b_done),
        .rdata(b_rdata), .sram_cs(b_sram_cs), .sram_we(b_sram_we), .sram_addr(b_sram_addr),
        .sram_wdata(b_sram_wdata), .sram_rdata(b_sram_rdata)
    );

    // SRAM models, filled with an address pattern on the first clock
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic        mem_init = 1'b0;
    always @(posedge wb_clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) begin
                mem_a[i] <= bg(10'(i));
                mem_b[i] <= bg(10'(i));
            end
            mem_init <= 1'b1;
        end else begin
            if (a_sram_cs && a_sram_we) mem_a[a_sram_addr] <= a_sram_wdata;
            if (b_sram_cs && b_sram_we) mem_b[b_sram_addr] <= b_sram_wdata;
        end
    end
    assign a_sram_rdata = mem_a[a_sram_addr];
    assign b_sram_rdata = mem_b[b_sram_addr];

    // Scoreboard monitors
    int    a_gcyc = 0, b_gcyc = 0, a_dcnt = 0, b_dcnt = 0, a_run = 0, b_run = 0;
    done_t a_d, b_d;
    wr_t   a_w, b_w;

    always @(negedge wb_clk) begin
        if (a_grant != '0) begin
            if (exp_g_a.size() == 0) chk("a_grant_unexpected", a_grant, 0);
            else                     chk("a_grant", a_grant, exp_g_a.pop_front());
            chk("a_cs_at_grant", a_sram_cs, 1);
            a_gcyc = cyc;
            if (a_sram_we) begin
                if (exp_w_a.size() == 0) chk("a_wr_unexpected", 1, 0);
                else begin
                    a_w = exp_w_a.pop_front();
                    chk("a_wr_addr", a_sram_addr, a_w.addr);
                    chk("a_wr_data", a_sram_wdata, a_w.data);
                end
            end
        end
        if (a_done != '0) begin
            a_dcnt++;
            if (exp_d_a.size() == 0) chk("a_done_unexpected", a_done, 0);
            else begin
                a_d = exp_d_a.pop_front();
                chk("a_done", a_done, a_d.done);
                chk("a_rdata", a_rdata, a_d.rdata);
                chk("a_done_latency", cyc - a_gcyc, WS_A + 1);
                chk("a_cs_low_at_done", a_sram_cs, 0);
            end
        end
        if (!rst_a) a_run = 0;
        else if (a_sram_cs) a_run++;
        else if (a_run != 0) begin chk("a_cs_len", a_run, WS_A + 1); a_run = 0; end
    end

    always @(negedge wb_clk) begin
        if (b_grant != '0) begin
            if (exp_g_b.size() == 0) chk("b_grant_unexpected", b_grant, 0);
            else                     chk("b_grant", b_grant, exp_g_b.pop_front());
            chk("b_cs_at_grant", b_sram_cs, 1);
            b_gcyc = cyc;
            if (b_sram_we) begin
                if (exp_w_b.size() == 0) chk("b_wr_unexpected", 1, 0);
                else begin
                    b_w = exp_w_b.pop_front();
                    chk("b_wr_addr", b_sram_addr, b_w.addr);
                    chk("b_wr_data", b_sram_wdata, b_w.data);
                end
            end
        end
        if (b_done != '0) begin
            b_dcnt++;
            if (exp_d_b.size() == 0) chk("b_done_unexpected", b_done, 0);
            else begin
                b_d = exp_d_b.pop_front();
                chk("b_done", b_done, b_d.done);
                chk("b_rdata", b_rdata, b_d.rdata);
                chk("b_done_latency", cyc - b_gcyc, WS_B + 1);
                chk("b_cs_low_at_done", b_sram_cs, 0);
            end
        end
        if (!rst_b) b_run = 0;
        else if (b_sram_cs) b_run++;
        else if (b_run != 0) begin chk("b_cs_len", b_run, WS_B + 1); b_run = 0; end
    end

    task automatic drain();
        for (int k = 0; k < 60 && (exp_d_a.size() != 0 || exp_d_b.size() != 0); k++) @(negedge wb_clk);
        chk("drain_a", exp_d_a.size(), 0);
        chk("drain_b", exp_d_b.size(), 0);
    endtask

    task automatic a_one(input int i, input logic we, input logic [9:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd);
        done_t d;
        wr_t   w;
        bit    got;
        exp_g_a.push_back(4'(1) << i);
        if (we) begin w.addr = addr; w.data = wd; exp_w_a.push_back(w); end
        else    a_hold = exp_rd;
        d.done = 4'(1) << i; d.rdata = a_hold; exp_d_a.push_back(d);
        @(posedge wb_clk); #1;
        a_req_we[i] = we; a_req_addr[i*10 +: 10] = addr; a_req_wdata[i*32 +: 32] = wd; a_req[i] = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge wb_clk);
            if (a_grant[i]) got = 1;
        end
        a_req[i] = 1'b0;
        if (!got) chk("a_grant_timeout", 0, 1);
        drain();
    endtask

    task automatic b_one(input int i, input logic we, input logic [9:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd);
        done_t d;
        wr_t   w;
        bit    got;
        exp_g_b.push_back(4'(1) << i);
        if (we) begin w.addr = addr; w.data = wd; exp_w_b.push_back(w); end
        else    b_hold = exp_rd;
        d.done = 4'(1) << i; d.rdata = b_hold; exp_d_b.push_back(d);
        @(posedge wb_clk); #1;
        b_req_we[i] = we; b_req_addr[i*10 +: 10] = addr; b_req_wdata[i*32 +: 32] = wd; b_req[i] = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge wb_clk);
            if (b_grant[i]) got = 1;
        end
        b_req[i] = 1'b0;
        if (!got) chk("b_grant_timeout", 0, 1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int    gc[5];
    int    ng;
    int    idx;
    int    dc;
    done_t d0;

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        a_req = 2'b11; a_req_we = '0; a_req_addr = {10'd6, 10'd5}; a_req_wdata = '0;
        b_req = 4'hF;  b_req_we = '0; b_req_addr = {10'h13, 10'h12, 10'h11, 10'h10}; b_req_wdata = '0;
        repeat (3) @(negedge wb_clk);
        chk("rst_a_grant_done", {a_grant, a_done}, 0);
        chk("rst_a_cs_we", {a_sram_cs, a_sram_we}, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_a_addr_wdata", {a_sram_addr, a_sram_wdata}, 0);
        chk("rst_b_grant_done", {b_grant, b_done}, 0);
        chk("rst_b_cs_we", {b_sram_cs, b_sram_we}, 0);

        // Both A requesters held high from reset: alternate (or requester 0 only), one access per 3 cycles
        for (int k = 0; k < 3; k++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            idx = 0;
`else
            idx = k % 2;
`endif
            exp_g_a.push_back(4'(1) << idx);
            d0.done = 4'(1) << idx; d0.rdata = bg(10'(5 + idx)); exp_d_a.push_back(d0);
            a_hold = d0.rdata;
        end
        @(posedge wb_clk); #1; rst_a = 1'b1;
        ng = 0;
        for (int k = 0; k < 40 && ng < 3; k++) begin
            @(negedge wb_clk);
            if (a_grant != '0) begin
                gc[ng] = cyc; ng++;
                if (ng == 3) a_req = '0;
            end
        end
        a_req = '0;
        chk("a_rr_grants_seen", ng, 3);
        chk("a_b2b_period_1", gc[1] - gc[0], WS_A + 3);
        chk("a_b2b_period_2", gc[2] - gc[1], WS_A + 3);
        drain();

        // Single accesses on A: write, read-back, top-of-range address
        a_one(1, 1'b1, 10'h3,   32'hDEADBEEF, '0);
        a_one(1, 1'b0, 10'h3,   '0, 32'hDEADBEEF);
        a_one(0, 1'b1, 10'h3FF, 32'hFFFF_FFFF, '0);
        a_one(0, 1'b0, 10'h3FF, '0, 32'hFFFF_FFFF);
        a_one(1, 1'b0, 10'h7,   '0, bg(10'h7));

        // B has been in reset all along with requests high
        chk("rst_b_held_outs", {b_grant, b_done, b_sram_cs, b_sram_we}, 0);
        chk("rst_b_held_rdata", b_rdata, 0);

        // All four B requesters held: pointer wraps 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            idx = 0;
`else
            idx = k % 4;
`endif
            exp_g_b.push_back(4'(1) << idx);
            d0.done = 4'(1) << idx; d0.rdata = bg(10'(16 + idx)); exp_d_b.push_back(d0);
            b_hold = d0.rdata;
        end
        @(posedge wb_clk); #1; rst_b = 1'b1;
        ng = 0;
        for (int k = 0; k < 60 && ng < 5; k++) begin
            @(negedge wb_clk);
            if (b_grant != '0) begin
                gc[ng] = cyc; ng++;
                if (ng == 5) b_req = '0;
            end
        end
        b_req = '0;
        chk("b_wrap_grants_seen", ng, 5);
        chk("b_b2b_period", gc[4] - gc[3], WS_B + 3);
        drain();

        // Read with wait states after writing the location
        b_one(2, 1'b1, 10'h20, 32'h12345678, '0);
        b_one(0, 1'b0, 10'h20, '0, 32'h12345678);
        b_one(3, 1'b0, 10'h3FF, '0, bg(10'h3FF));

        // Reset in the middle of a B access: select drops at once, no done
        exp_g_b.push_back(4'b0010);
        @(posedge wb_clk); #1;
        b_req_we[1] = 1'b0; b_req_addr[10 +: 10] = 10'h44; b_req[1] = 1'b1;
        ng = 0;
        for (int k = 0; k < 20 && ng == 0; k++) begin
            @(negedge wb_clk);
            if (b_grant[1]) ng = 1;
        end
        b_req = '0;
        chk("b_mid_grant_seen", ng, 1);
        @(posedge wb_clk); #1;
        chk("b_cs_before_rst", b_sram_cs, 1);
        dc = b_dcnt;
        rst_b = 1'b0;
        #1;
        chk("b_cs_on_rst", b_sram_cs, 0);
        chk("b_grant_on_rst", b_grant, 0);
        repeat (2) @(posedge wb_clk);
        #1 rst_b = 1'b1;
        repeat (8) @(negedge wb_clk);
        chk("b_no_done_after_rst", b_dcnt, dc);
        chk("b_rdata_after_rst", b_rdata, 0);

        chk("left_grant_a", exp_g_a.size(), 0);
        chk("left_grant_b", exp_g_b.size(), 0);
        chk("left_wr_a", exp_w_a.size(), 0);
        chk("left_wr_b", exp_w_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
